// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit.
//   - access size encodings carried on req_size
//   - FSM state encoding
//   - misalignment check used when a request is accepted
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_STORE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

    // A request is rejected when it straddles its natural alignment or
    // carries the unused size code.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] byte_off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = byte_off[0];
            SZ_WORD: bad = (byte_off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Bundles the core-side request/response signals and the data-memory port.
//   slave  : view of the load/store unit
//   master : view of the surrounding core + memory (or a testbench)
// Core side  : req_valid, req_write, req_size, req_unsigned, req_addr,
//              req_wdata -> ; <- stall, done, rdata, misalign
// Memory side: <- mem_addr, mem_wdata, mem_we, mem_re ; mem_rdata ->
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic              done;
    logic [31:0]       rdata;
    logic              misalign;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr,
               req_wdata, mem_rdata,
        output stall, done, rdata, misalign, mem_addr, mem_wdata, mem_we,
               mem_re
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr,
               req_wdata, mem_rdata,
        input  stall, done, rdata, misalign, mem_addr, mem_wdata, mem_we,
               mem_re
    );
endinterface

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane steering (little-endian lanes).
//   byte_off    in  2  : low address bits of the access
//   size        in  2  : SZ_BYTE / SZ_HALF / SZ_WORD
//   is_unsigned in  1  : zero-extend instead of sign-extend on loads
//   load_word   in  32 : word read from memory
//   load_result out 32 : extracted and extended load value
//   old_word    in  32 : word read during a read-modify-write
//   new_data    in  16 : low half of the store data
//   merged_word out 32 : old_word with the addressed lane(s) replaced
// Word stores never go through the merge path, so new_data only needs the
// low 16 bits; for word size the merge leaves old_word untouched.
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] load_word,
    output logic [31:0] load_result,
    input  logic [31:0] old_word,
    input  logic [15:0] new_data,
    output logic [31:0] merged_word
);

    logic [7:0]  lane_byte_s;
    logic [15:0] lane_half_s;
    logic        sign_s;

    // Load lane extraction and sign/zero extension.
    always_comb begin
        lane_byte_s = load_word[{byte_off, 3'b000} +: 8];
        lane_half_s = byte_off[1] ? load_word[31:16] : load_word[15:0];
        sign_s      = 1'b0;
        load_result = load_word;
        case (size)
            SZ_BYTE: begin
                sign_s      = ~is_unsigned & lane_byte_s[7];
                load_result = {{24{sign_s}}, lane_byte_s};
            end
            SZ_HALF: begin
                sign_s      = ~is_unsigned & lane_half_s[15];
                load_result = {{16{sign_s}}, lane_half_s};
            end
            default: load_result = load_word;
        endcase
    end

    // Store merge: overwrite only the addressed byte or half-word.
    always_comb begin
        merged_word = old_word;
        case (size)
            SZ_BYTE: merged_word[{byte_off, 3'b000} +: 8] = new_data[7:0];
            SZ_HALF: begin
                if (byte_off[1]) begin
                    merged_word[31:16] = new_data;
                end else begin
                    merged_word[15:0] = new_data;
                end
            end
            default: merged_word = old_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Converts byte-addressed loads/stores from the core into accesses on a
// word-addressed memory. Sub-word stores use read-modify-write. The core is
// stalled until the access finishes; misaligned/illegal requests complete
// with misalign=1 and never touch memory.
//   clk  in 1 : clock, rising edge
//   rst  in 1 : synchronous active-high reset
//   bus  slave modport of load_store_unit_if (request, response, memory port)
// Parameters: ADDR_W byte-address width, MEM_DEPTH memory depth in words.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    lsu_state_e        state_r;
    lsu_state_e        state_next_s;
    logic              accept_s;
    logic              mis_s;
    logic [1:0]        size_r;
    logic              unsigned_r;
    // Only the word-index and lane bits are kept; higher bits wrap away.
    logic [IDX_W+1:0]  addr_r;
    logic [15:0]       wdata_r;
    logic [31:0]       merge_r;
    logic              err_r;
    logic [31:0]       rdata_r;
    logic [31:0]       load_result_s;
    logic [31:0]       merged_s;
    logic              idle_s;

    assign mis_s  = is_misaligned(bus.req_size, bus.req_addr[1:0]);
    assign idle_s = (state_r == ST_IDLE);

    lsu_lane_align u_align (
        .byte_off    (addr_r[1:0]),
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .load_word   (bus.mem_rdata),
        .load_result (load_result_s),
        .old_word    (bus.mem_rdata),
        .new_data    (wdata_r),
        .merged_word (merged_s)
    );

    // Next-state decode; requests are only accepted in IDLE.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    if (mis_s) begin
                        state_next_s = ST_RESP;
                    end else if (!bus.req_write) begin
                        state_next_s = ST_LOAD;
                    end else if (bus.req_size == SZ_WORD) begin
                        state_next_s = ST_STORE;
                    end else begin
                        state_next_s = ST_RMW_RD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD:   state_next_s = ST_RESP;
            ST_RMW_RD: state_next_s = ST_STORE;
            ST_STORE:  state_next_s = ST_RESP;
            ST_RESP:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // State, request latches, merge buffer and load result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            size_r     <= 2'b00;
            unsigned_r <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 16'h0000;
            merge_r    <= 32'h0000_0000;
            err_r      <= 1'b0;
            rdata_r    <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                size_r     <= bus.req_size;
                unsigned_r <= bus.req_unsigned;
                addr_r     <= bus.req_addr[IDX_W+1:0];
                wdata_r    <= bus.req_wdata[15:0];
                err_r      <= mis_s;
                if (mis_s) begin
                    rdata_r <= 32'h0000_0000;
                end
                // Word stores skip the read phase and write req_wdata as-is.
                if (bus.req_write && (bus.req_size == SZ_WORD)) begin
                    merge_r <= bus.req_wdata;
                end
            end
            if (state_r == ST_LOAD) begin
                rdata_r <= load_result_s;
            end
            if (state_r == ST_RMW_RD) begin
                merge_r <= merged_s;
            end
        end
    end

    // Output decode; everything is held low while reset is asserted so an
    // abandoned access can never strobe the memory.
    always_comb begin
        bus.stall     = 1'b0;
        bus.done      = 1'b0;
        bus.misalign  = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0000_0000;
        bus.mem_wdata = 32'h0000_0000;
        bus.rdata     = rdata_r;
        if (!rst) begin
            bus.stall    = (idle_s && bus.req_valid) || (state_r == ST_LOAD) ||
                           (state_r == ST_RMW_RD) || (state_r == ST_STORE);
            bus.done     = (state_r == ST_RESP);
            bus.misalign = (state_r == ST_RESP) && err_r;
            bus.mem_re   = (state_r == ST_LOAD) || (state_r == ST_RMW_RD);
            bus.mem_we   = (state_r == ST_STORE);
            if (!idle_s) begin
                bus.mem_addr = {{(32-IDX_W){1'b0}}, addr_r[IDX_W+1:2]};
            end else begin
                bus.mem_addr = 32'h0000_0000;
            end
            if (state_r == ST_STORE) begin
                bus.mem_wdata = merge_r;
            end else begin
                bus.mem_wdata = 32'h0000_0000;
            end
        end else begin
            bus.stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Table-driven bench with a scoreboard queue and a behavioural word memory.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        int          exp_lat;
        int          exp_we;
        int          exp_re;
        logic [6:0]  exp_idx;
        logic [31:0] exp_word;
    } vec_t;

    logic clk;
    logic rst;
    logic [31:0] mem [0:127];

    int n_vec;
    int n_mis;
    int we_cnt;
    int re_cnt;
    int done_cnt;
    logic [6:0]  last_idx;

    vec_t vecs [0:14];
    vec_t sb_q [$];

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .MEM_DEPTH(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational read, write on the rising edge.
    assign bus.mem_rdata = mem[bus.mem_addr[6:0]];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[6:0]] <= bus.mem_wdata;
    end

    // Strobe monitor sampled mid-cycle.
    initial begin
        we_cnt = 0; re_cnt = 0; done_cnt = 0; last_idx = 7'd0;
        forever begin
            @(negedge clk);
            if (bus.mem_we) begin we_cnt++; last_idx = bus.mem_addr[6:0]; end
            if (bus.mem_re) begin re_cnt++; last_idx = bus.mem_addr[6:0]; end
            if (bus.done) done_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   lat;
        int   we0;
        int   re0;
        logic got;
        vec_t e;
        sb_q.push_back(v);
        bus.req_valid    = 1'b1;
        bus.req_write    = v.wr;
        bus.req_size     = v.sz;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wd;
        we0 = we_cnt; re0 = re_cnt; lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk); lat++; #1;
            if (bus.done) got = 1'b1;
        end
        bus.req_valid = 1'b0;
        e = sb_q.pop_front();
        if (!got) begin
            n_vec++; n_mis++;
            $display("FAIL timeout addr=%h: no done within 20 cycles", e.addr);
        end else begin
            chk("rdata", bus.rdata, e.exp_rdata);
            chk("misalign", {31'd0, bus.misalign}, {31'd0, e.exp_mis});
            chk("latency", lat, e.exp_lat);
            chk("we_pulses", we_cnt - we0, e.exp_we);
            chk("re_pulses", re_cnt - re0, e.exp_re);
            chk("mem_word", mem[e.exp_idx], e.exp_word);
            if (e.exp_we + e.exp_re > 0) chk("mem_addr", {25'd0, last_idx}, {25'd0, e.exp_idx});
            @(posedge clk); #1;
            chk("done_one_cycle", {30'd0, bus.done, bus.stall}, 32'd0);
        end
    endtask

    initial begin
        n_vec = 0; n_mis = 0;
        //            wr    sz     uns   addr          wd            rdata         mis  lat we re idx    word
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 1, 0, 7'd4, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0, 1, 7'd4, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00A5, 32'hDEAD_BEEF, 1'b0, 3, 1, 1, 7'd4, 32'hA5AD_BEEF};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         32'hFFFF_FFA5, 1'b0, 2, 0, 1, 7'd4, 32'hA5AD_BEEF};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         32'h0000_00A5, 1'b0, 2, 0, 1, 7'd4, 32'hA5AD_BEEF};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'hFFFF_A5AD, 1'b0, 2, 0, 1, 7'd4, 32'hA5AD_BEEF};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,         32'h0000_BEEF, 1'b0, 2, 0, 1, 7'd4, 32'hA5AD_BEEF};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'h5555_1234, 32'h0000_BEEF, 1'b0, 3, 1, 1, 7'd4, 32'hA5AD_1234};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0210, 32'h0,         32'hA5AD_1234, 1'b0, 2, 0, 1, 7'd4, 32'hA5AD_1234};
        vecs[9]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0034, 1'b0, 2, 0, 1, 7'd4, 32'hA5AD_1234};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1, 1, 0, 0, 7'd4, 32'hA5AD_1234};
        vecs[11] = '{1'b0, 2'b01, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1, 1, 0, 0, 7'd4, 32'hA5AD_1234};
        vecs[12] = '{1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1, 0, 0, 7'd4, 32'hA5AD_1234};
        vecs[13] = '{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0, 2, 1, 0, 7'd8, 32'h1122_3344};
        vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h1122_3344, 1'b0, 2, 0, 1, 7'd8, 32'h1122_3344};

        // Reset held for two cycles with a pending request.
        rst = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0000_0010; bus.req_wdata = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {27'd0, bus.stall, bus.done, bus.misalign, bus.mem_we, bus.mem_re}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'h0000_0000);
        chk("rst_mem_addr", bus.mem_addr, 32'h0000_0000);
        rst = 1'b0; bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", {30'd0, bus.stall, bus.done}, 32'd0);
        chk("post_rst_no_write", we_cnt, 0);

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // Reset during the read phase of a half-word store to word 8.
        begin
            int we0;
            int dn0;
            we0 = we_cnt; dn0 = done_cnt;
            bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b01;
            bus.req_unsigned = 1'b0; bus.req_addr = 32'h0000_0022; bus.req_wdata = 32'h0000_BEEF;
            @(posedge clk); #1;
            chk("rmw_rd_re", {30'd0, bus.mem_re, bus.stall}, 32'd3);
            rst = 1'b1; #1;
            chk("rst_forces_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
            @(posedge clk); #1;
            rst = 1'b0; bus.req_valid = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            chk("abort_no_write", we_cnt - we0, 0);
            chk("abort_no_done", done_cnt - dn0, 0);
            chk("abort_word8", mem[8], 32'h1122_3344);
            chk("abort_idle", {31'd0, bus.stall}, 32'd0);
            chk("abort_idle_addr", bus.mem_addr, 32'h0000_0000);
        end

        run_vec(vecs[14]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
